// File: rtl/osc_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : osc_freq_monitor
// Brief    : Counts synchronized rising edges of an on-chip oscillator over a
//            fixed system-clock window and flags out-of-band or lost clock.
//            Optional sticky fault interrupt when OSC_MON_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module osc_freq_monitor #(
  parameter int WINDOW_CYCLES = 500000,
  parameter int COUNT_W       = 16,
  parameter int LIMIT_LO      = 320,
  parameter int LIMIT_HI      = 336
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mon_clk,
  output logic [COUNT_W-1:0] freq_count,
  output logic               count_valid,
  output logic               freq_ok,
  output logic               clk_lost,
  output logic               busy
`ifdef OSC_MON_IRQ_EN
  ,
  output logic               irq,
  input  logic               irq_clr
`endif
);

  localparam int                 c_win_w    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] c_cnt_max  = '1;
  localparam logic [COUNT_W-1:0] c_limit_lo = COUNT_W'(LIMIT_LO);
  localparam logic [COUNT_W-1:0] c_limit_hi = COUNT_W'(LIMIT_HI);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic               w_edge;
  logic [c_win_w-1:0] r_win_cnt;
  logic [COUNT_W-1:0] r_edge_cnt;
  logic               w_win_last;
  logic               w_in_band;
  logic               w_lost;
  logic [COUNT_W-1:0] r_freq_count;
  logic               r_count_valid;
  logic               r_freq_ok;
  logic               r_clk_lost;

  // mon_clk is asynchronous: two flops for metastability, a third for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= mon_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge     = r_s2 & ~r_s3;
  assign w_win_last = (r_win_cnt == c_win_last);
  assign w_in_band  = (r_edge_cnt >= c_limit_lo) && (r_edge_cnt <= c_limit_hi);
  assign w_lost     = (r_edge_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_next = S_MEASURE;
        end
      end
      S_MEASURE: begin
        busy = 1'b1;
        if (!enable) begin
          w_state_next = S_IDLE;
        end else if (w_win_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = enable ? S_MEASURE : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Counters only run in MEASURE; an abort discards the partial window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else begin
      if (r_state == S_MEASURE && enable) begin
        r_win_cnt <= w_win_last ? '0 : r_win_cnt + 1'b1;
        if (w_edge && (r_edge_cnt != c_cnt_max)) begin
          r_edge_cnt <= r_edge_cnt + 1'b1;
        end
      end else begin
        r_win_cnt  <= '0;
        r_edge_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq_count  <= '0;
      r_count_valid <= 1'b0;
      r_freq_ok     <= 1'b0;
      r_clk_lost    <= 1'b0;
    end else begin
      r_count_valid <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_freq_count <= r_edge_cnt;
        r_freq_ok    <= w_in_band;
        r_clk_lost   <= w_lost;
      end
    end
  end

  assign freq_count  = r_freq_count;
  assign count_valid = r_count_valid;
  assign freq_ok     = r_freq_ok;
  assign clk_lost    = r_clk_lost;

`ifdef OSC_MON_IRQ_EN
  logic r_irq;
  logic w_irq_set;

  // Set is registered alongside the results so it appears with count_valid
  assign w_irq_set = (r_state == S_DONE) && (!w_in_band || w_lost);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_osc_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_osc_freq_monitor
// Brief    : Directed/random bench for osc_freq_monitor; exact pulse bursts are
//            placed inside each window and compared with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_osc_freq_monitor;

  localparam int W = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mon_clk = 1'b0;
  logic        irq_clr = 1'b0;
  logic [15:0] freq_count;
  logic        count_valid, freq_ok, clk_lost, busy;
  logic [3:0]  sat_count;
  logic        sat_valid, sat_ok, sat_lost, sat_busy;
`ifdef OSC_MON_IRQ_EN
  logic        irq, sat_irq;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  logic exp_ok   = 1'b0;
  logic exp_lost = 1'b0;
  logic exp_irq  = 1'b0;

  osc_freq_monitor #(.WINDOW_CYCLES(W), .COUNT_W(16), .LIMIT_LO(45), .LIMIT_HI(55)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mon_clk(mon_clk),
    .freq_count(freq_count), .count_valid(count_valid), .freq_ok(freq_ok),
    .clk_lost(clk_lost), .busy(busy)
`ifdef OSC_MON_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

  osc_freq_monitor #(.WINDOW_CYCLES(W), .COUNT_W(4), .LIMIT_LO(5), .LIMIT_HI(10)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mon_clk(mon_clk),
    .freq_count(sat_count), .count_valid(sat_valid), .freq_ok(sat_ok),
    .clk_lost(sat_lost), .busy(sat_busy)
`ifdef OSC_MON_IRQ_EN
    , .irq(sat_irq), .irq_clr(irq_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Emit exactly n pulses (period 8 CLK) well inside the window, then wait for the result
  task automatic measure(input int n, input int exp_lat, input string tag);
    int cyc;
    bit seen;
    int sat_exp;
    cyc  = 0;
    seen = 1'b0;
    repeat (5) begin tick(); cyc++; end
    for (int i = 0; i < n; i++) begin
      mon_clk = 1'b1;
      repeat (4) begin tick(); cyc++; end
      mon_clk = 1'b0;
      repeat (4) begin tick(); cyc++; end
    end
    while (!seen && cyc < exp_lat + 20) begin
      tick();
      cyc++;
      seen = (count_valid === 1'b1);
    end
    exp_cnt  = n;
    exp_ok   = (n >= 45) && (n <= 55);
    exp_lost = (n == 0);
    sat_exp  = (n > 15) ? 15 : n;
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " count"}, freq_count, exp_cnt);
    check({tag, " ok"}, freq_ok, exp_ok);
    check({tag, " lost"}, clk_lost, exp_lost);
    check({tag, " sat_valid"}, sat_valid, 1);
    check({tag, " sat_count"}, sat_count, sat_exp);
    check({tag, " sat_ok"}, sat_ok, (sat_exp >= 5) && (sat_exp <= 10));
`ifdef OSC_MON_IRQ_EN
    if (!exp_ok || exp_lost) exp_irq = 1'b1;
    check({tag, " irq"}, irq, exp_irq);
`endif
  endtask

  initial begin
    int n;
    int valids;
    int dir_list[8] = '{45, 55, 44, 56, 100, 8, 16, 120};

    repeat (3) tick();
    check("rst count", freq_count, 0);
    check("rst valid", count_valid, 0);
    check("rst ok", freq_ok, 0);
    check("rst lost", clk_lost, 0);
    check("rst busy", busy, 0);
    check("rst sat_count", sat_count, 0);
`ifdef OSC_MON_IRQ_EN
    check("rst irq", irq, 0);
`endif
    rst_n = 1'b1;
    tick();
    check("idle busy", busy, 0);

    enable = 1'b1;
    measure(50, W + 2, "w50");
    measure(0, W + 1, "b2b_w0");
    enable  = 1'b0;
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    exp_irq = 1'b0;
    check("disable busy", busy, 0);
`ifdef OSC_MON_IRQ_EN
    check("irq cleared", irq, 0);
`endif

    for (int i = 0; i < 11; i++) begin
      n = (i < 8) ? dir_list[i] : int'($urandom_range(0, 120));
      tick();
      enable = 1'b1;
      measure(n, W + 2, $sformatf("n%0d", n));
      enable = 1'b0;
      if (i % 2 == 1) begin
        irq_clr = 1'b1;
        exp_irq = 1'b0;
      end
      tick();
      irq_clr = 1'b0;
      check("idle after window", busy, 0);
`ifdef OSC_MON_IRQ_EN
      check("irq after clr step", irq, exp_irq);
`endif
    end

    // Abort midway through the second window
    enable = 1'b1;
    measure(50, W + 2, "pre_abort");
    for (int i = 0; i < 500; i++) begin
      mon_clk = ((i / 5) % 2 == 1);
      tick();
    end
    mon_clk = 1'b0;
    enable  = 1'b0;
    tick();
    check("abort busy", busy, 0);
    valids = 0;
    repeat (W + 10) begin
      tick();
      if (count_valid === 1'b1) valids++;
    end
    check("abort no valid", valids, 0);
    check("abort held count", freq_count, 50);
    check("abort held ok", freq_ok, 1);
    check("abort held lost", clk_lost, 0);
    enable = 1'b1;
    measure(47, W + 2, "post_abort");

    // Asynchronous reset in the middle of a window
    repeat (300) tick();
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("midrst count", freq_count, 0);
    check("midrst valid", count_valid, 0);
    check("midrst ok", freq_ok, 0);
    check("midrst lost", clk_lost, 0);
    check("midrst busy", busy, 0);
    check("midrst sat_count", sat_count, 0);
    exp_irq = 1'b0;
`ifdef OSC_MON_IRQ_EN
    check("midrst irq", irq, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    measure(52, W + 2, "post_rst");
    enable = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
